key_note_encoder: RTL and testbench

Upstream input stage of the piezo/segment note player. Takes the eight raw key switches, synchronises and debounces each one, priority-encodes the held keys into a 3-bit note index, and emits single-cycle press/release events. The player stage consumes `note`, `note_valid` and `press_pulse` in place of the raw switch vector.

---
 rtl/key_pkg.sv | 38 +++
 rtl/key_debounce_bit.sv | 50 +++++
 rtl/key_note_encoder.sv | 131 +++++++++++++
 tb/tb_key_note_encoder.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// Shared types and constants for the key-switch front end of the note player.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: none; this package holds no logic.
package key_pkg;

    localparam int N_KEYS = 8;

    // Note indices, one per key, lowest key first.
    localparam logic [2:0] NOTE_DO    = 3'd0;
    localparam logic [2:0] NOTE_RE    = 3'd1;
    localparam logic [2:0] NOTE_MI    = 3'd2;
    localparam logic [2:0] NOTE_FA    = 3'd3;
    localparam logic [2:0] NOTE_SOL   = 3'd4;
    localparam logic [2:0] NOTE_LA    = 3'd5;
    localparam logic [2:0] NOTE_SI    = 3'd6;
    localparam logic [2:0] NOTE_DO_HI = 3'd7;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HELD = 1'b1
    } key_state_t;

    // Lowest held key wins; returns NOTE_DO when nothing is held.
    function automatic logic [2:0] lowest_key(input logic [N_KEYS-1:0] keys);
        logic [2:0] idx;
        if (keys[0])      idx = NOTE_DO;
        else if (keys[1]) idx = NOTE_RE;
        else if (keys[2]) idx = NOTE_MI;
        else if (keys[3]) idx = NOTE_FA;
        else if (keys[4]) idx = NOTE_SOL;
        else if (keys[5]) idx = NOTE_LA;
        else if (keys[6]) idx = NOTE_SI;
        else if (keys[7]) idx = NOTE_DO_HI;
        else              idx = NOTE_DO;
        return idx;
    endfunction

endpackage

// File: rtl/key_debounce_bit.sv
// Per-key synchroniser plus counting debouncer producing a clean level.
// Latency: 2 sync cycles plus STABLE_CNT sample ticks to accept a change.
// Backpressure: none; free-running, samples only when tick is high.
module key_debounce_bit #(
    parameter int STABLE_CNT = 4
) (
    input  logic clk,
    input  logic resetn,
    input  logic tick,
    input  logic raw,
    output logic stable
);

    localparam int CNT_W = $clog2(STABLE_CNT + 1);

    logic             sync1;
    logic             in_s;
    logic [CNT_W-1:0] cnt;

    // Two-flop synchroniser for the asynchronous switch input.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1 <= 1'b0;
            in_s  <= 1'b0;
        end else begin
            sync1 <= raw;
            in_s  <= sync1;
        end
    end

    // Count consecutive differing samples; any agreeing sample restarts the count.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stable <= 1'b0;
            cnt    <= '0;
        end else if (tick) begin
            if (in_s != stable) begin
                if (int'(cnt) + 1 >= STABLE_CNT) begin
                    stable <= ~stable;
                    cnt    <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/key_note_encoder.sv
// Debounces eight key switches, picks the lowest held key, emits press/release strobes.
// Latency: 2 sync + up to STABLE_CNT ticks (first up to TICK_DIV cycles away) + 1 cycle.
// Backpressure: none; strobes are single-cycle. Optional auto-repeat: KEY_AUTOREPEAT_EN.
module key_note_encoder
    import key_pkg::*;
#(
    parameter int TICK_DIV     = 1000,
    parameter int STABLE_CNT   = 4,
    parameter int REPEAT_TICKS = 250
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [N_KEYS-1:0] in,
    output logic [2:0]        note,
    output logic              note_valid,
    output logic              press_pulse,
    output logic              release_pulse
);

    localparam int PRE_W = $clog2(TICK_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    logic [PRE_W-1:0]  pre;
    logic              tick;
    logic [N_KEYS-1:0] stable;
    logic [2:0]        enc;
    logic              any;
    key_state_t        state;

    assign tick = (pre == PRE_LAST);

    // Free-running sample prescaler shared by all keys.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pre <= '0;
        end else if (tick) begin
            pre <= '0;
        end else begin
            pre <= pre + 1'b1;
        end
    end

    for (genvar i = 0; i < N_KEYS; i++) begin : g_key
        key_debounce_bit #(
            .STABLE_CNT (STABLE_CNT)
        ) u_db (
            .clk    (clk),
            .resetn (resetn),
            .tick   (tick),
            .raw    (in[i]),
            .stable (stable[i])
        );
    end

    assign enc = lowest_key(stable);
    assign any = |stable;

`ifdef KEY_AUTOREPEAT_EN
    localparam int RPT_W = $clog2(REPEAT_TICKS + 1);

    logic             tick_q;
    logic [RPT_W-1:0] rpt;

    // Delay tick by one cycle so repeat strobes line up with the cycle in which
    // debounced levels change; a change and a repeat then collide cleanly.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tick_q <= 1'b0;
        end else begin
            tick_q <= tick;
        end
    end
`else
    // Repeat interval has no effect without auto-repeat.
    logic [31:0] unused_repeat_ticks;
    assign unused_repeat_ticks = 32'(REPEAT_TICKS);
`endif

    // Note tracking FSM with registered outputs; at most one event per cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state         <= ST_IDLE;
            note          <= NOTE_DO;
            note_valid    <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
`ifdef KEY_AUTOREPEAT_EN
            rpt           <= '0;
`endif
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (any) begin
                        note        <= enc;
                        note_valid  <= 1'b1;
                        press_pulse <= 1'b1;
                        state       <= ST_HELD;
`ifdef KEY_AUTOREPEAT_EN
                        rpt         <= '0;
`endif
                    end
                end
                ST_HELD: begin
                    if (!any) begin
                        note_valid    <= 1'b0;
                        release_pulse <= 1'b1;
                        state         <= ST_IDLE;
                    end else if (enc != note) begin
                        // Losing the selected key while another is held lands here too.
                        note        <= enc;
                        press_pulse <= 1'b1;
`ifdef KEY_AUTOREPEAT_EN
                        rpt         <= '0;
                    end else if (tick_q) begin
                        if (int'(rpt) + 1 >= REPEAT_TICKS) begin
                            press_pulse <= 1'b1;
                            rpt         <= '0;
                        end else begin
                            rpt <= rpt + 1'b1;
                        end
`endif
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_key_note_encoder.sv
// Directed bench for key_note_encoder with TICK_DIV=4, STABLE_CNT=3, REPEAT_TICKS=5.
// Latency: worst-case press/release expected within 15 cycles of an input edge.
// Backpressure: n/a; pulses are counted by a monitor and checked at each step.
module tb_key_note_encoder;

    logic       clk;
    logic       resetn;
    logic [7:0] in_keys;
    logic [2:0] note;
    logic       note_valid;
    logic       press_pulse;
    logic       release_pulse;

    int checks;
    int errors;
    int press_cnt;
    int release_cnt;
    int overlap_cnt;

    key_note_encoder #(
        .TICK_DIV     (4),
        .STABLE_CNT   (3),
        .REPEAT_TICKS (5)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .in            (in_keys),
        .note          (note),
        .note_valid    (note_valid),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse monitor, sampling just after each rising edge.
    always @(posedge clk) begin
        #1;
        if (press_pulse)                  press_cnt++;
        if (release_pulse)                release_cnt++;
        if (press_pulse && release_pulse) overlap_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Wait up to budget falling edges for a press (rel=0) or release (rel=1).
    // Returns the edge index where it was seen, or -1.
    task automatic wait_pulse(input bit rel, input int budget, output int n);
        n = -1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if ((rel && release_pulse) || (!rel && press_pulse)) begin
                n = i;
                break;
            end
        end
    endtask

    int n;
    int pc;
    int rc;

    initial begin
        checks      = 0;
        errors      = 0;
        press_cnt   = 0;
        release_cnt = 0;
        overlap_cnt = 0;
        resetn      = 1'b0;
        in_keys     = 8'h00;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_note",    32'(note), 32'd0);
        check("rst_valid",   32'(note_valid), 32'd0);
        check("rst_press",   32'(press_pulse), 32'd0);
        check("rst_release", 32'(release_pulse), 32'd0);
        resetn = 1'b1;

        // 1: idle for 100 cycles
        repeat (100) @(negedge clk);
        check("idle_press_cnt",   32'(press_cnt), 32'd0);
        check("idle_release_cnt", 32'(release_cnt), 32'd0);
        check("idle_valid",       32'(note_valid), 32'd0);

        // 2: single clean press/release on key 0
        in_keys = 8'h01;
        wait_pulse(1'b0, 15, n);
        check("t2_press_seen", 32'(n > 0), 32'd1);
        check("t2_note",       32'(note), 32'd0);
        check("t2_valid",      32'(note_valid), 32'd1);
        repeat (3) @(negedge clk);
        check("t2_one_press",  32'(press_cnt), 32'd1);
        in_keys = 8'h00;
        wait_pulse(1'b1, 15, n);
        check("t2_release_seen", 32'(n > 0), 32'd1);
        check("t2_rel_valid",    32'(note_valid), 32'd0);
        check("t2_rel_note",     32'(note), 32'd0);
        repeat (3) @(negedge clk);
        check("t2_one_release",  32'(release_cnt), 32'd1);

        // 3: bouncing key 2, then settled
        pc = press_cnt;
        for (int k = 0; k < 10; k++) begin
            in_keys[2] = ~in_keys[2];
            repeat (4) @(negedge clk);
        end
        check("t3_bounce_no_press", 32'(press_cnt), 32'(pc));
        check("t3_bounce_valid",    32'(note_valid), 32'd0);
        in_keys = 8'h04;
        wait_pulse(1'b0, 15, n);
        check("t3_press_seen", 32'(n > 0), 32'd1);
        check("t3_note",       32'(note), 32'd2);
        repeat (3) @(negedge clk);
        check("t3_one_press",  32'(press_cnt), 32'(pc + 1));
        in_keys = 8'h00;
        wait_pulse(1'b1, 15, n);
        check("t3_release_seen", 32'(n > 0), 32'd1);

        // 4: note changes through the priority encoder
        in_keys = 8'h08;
        wait_pulse(1'b0, 15, n);
        check("t4_press_08", 32'(n > 0), 32'd1);
        check("t4_note_08",  32'(note), 32'd3);
        rc = release_cnt;
        in_keys = 8'h0C;
        wait_pulse(1'b0, 15, n);
        check("t4_press_0c", 32'(n > 0), 32'd1);
        check("t4_note_0c",  32'(note), 32'd2);
        check("t4_valid_0c", 32'(note_valid), 32'd1);
        in_keys = 8'h08;
        wait_pulse(1'b0, 15, n);
        check("t4_press_08b", 32'(n > 0), 32'd1);
        check("t4_note_08b",  32'(note), 32'd3);
        check("t4_no_release", 32'(release_cnt), 32'(rc));
        in_keys = 8'h00;
        wait_pulse(1'b1, 15, n);
        check("t4_release_seen", 32'(n > 0), 32'd1);

        // 5: reset while held, then fresh press after full latency
        in_keys = 8'h80;
        wait_pulse(1'b0, 15, n);
        check("t5_press", 32'(n > 0), 32'd1);
        check("t5_note",  32'(note), 32'd7);
        repeat (2) @(negedge clk);
        pc = press_cnt;
        rc = release_cnt;
        resetn = 1'b0;
        #1;
        check("t5_rst_note",  32'(note), 32'd0);
        check("t5_rst_valid", 32'(note_valid), 32'd0);
        repeat (2) @(negedge clk);
        check("t5_rst_no_press",   32'(press_cnt), 32'(pc));
        check("t5_rst_no_release", 32'(release_cnt), 32'(rc));
        resetn = 1'b1;
        wait_pulse(1'b0, 20, n);
        check("t5_repress_latency", 32'(n), 32'd13);
        check("t5_repress_note",    32'(note), 32'd7);
        check("t5_no_release",      32'(release_cnt), 32'(rc));
        in_keys = 8'h00;
        wait_pulse(1'b1, 15, n);
        check("t5_release_seen", 32'(n > 0), 32'd1);

        // 6: long hold on key 4
        pc = press_cnt;
        in_keys = 8'h10;
        wait_pulse(1'b0, 15, n);
        check("t6_press", 32'(n > 0), 32'd1);
        check("t6_note",  32'(note), 32'd4);
`ifdef KEY_AUTOREPEAT_EN
        wait_pulse(1'b0, 25, n);
        check("t6_repeat1_gap",  32'(n), 32'd20);
        check("t6_repeat1_note", 32'(note), 32'd4);
        wait_pulse(1'b0, 25, n);
        check("t6_repeat2_gap",  32'(n), 32'd20);
        check("t6_repeat2_note", 32'(note), 32'd4);
`else
        repeat (100) @(negedge clk);
        check("t6_single_press", 32'(press_cnt), 32'(pc + 1));
        check("t6_still_valid",  32'(note_valid), 32'd1);
`endif
        in_keys = 8'h00;
        wait_pulse(1'b1, 15, n);
        check("t6_release_seen", 32'(n > 0), 32'd1);

        check("no_overlap", 32'(overlap_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
